// File: rtl/mux_4_to_1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_to_1_rr
// Purpose  : Four-channel valid/ready round-robin merge into one registered
//            output stream tagged with its source channel.
// Revision : 1.0
// ============================================================================
module mux_4_to_1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;

  logic             w_free;
  logic             w_any;
  logic             w_grant;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;

  assign w_free = !r_valid || out_ready;

  // Scanning from the far end back toward ptr leaves the nearest requester in w_win.
  always_comb begin
    w_win = 2'd0;
    w_any = 1'b0;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (in_valid[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_grant  = rst_n && w_free && w_any;
  assign in_ready = w_grant ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_win*WIDTH +: WIDTH];
      r_sel   <= w_win;
      r_ptr   <= w_win + 2'd1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

  // A waiting requester must keep valid high with unchanged data until granted.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_in_proto
      a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid[gi] && !in_ready[gi]) |=>
        (in_valid[gi] && $stable(in_data[gi*WIDTH +: WIDTH])));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux_4_to_1_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4_to_1_rr
// Purpose  : Randomized and directed bench for mux_4_to_1_rr with a
//            reference model and per-lane loopback scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mux_4_to_1_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [7:0]  ch_data [4];
  logic [3:0]  hs;

  int n_checks;
  int n_fail;

  // Reference model state
  int         m_ptr;
  logic       m_ov;
  logic [7:0] m_od;
  int         m_os;

  // Per-lane loopback scoreboard (what a downstream demux would see per lane)
  logic [7:0] sb_mem [4][0:2047];
  int         sb_wr  [4];
  int         sb_rd  [4];

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  mux_4_to_1_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input int lane, input logic [7:0] data);
    if (sb_rd[lane] < sb_wr[lane]) begin
      check("loopback_data", 32'(data), 32'(sb_mem[lane][sb_rd[lane]]));
      sb_rd[lane]++;
    end else begin
      check("loopback_extra", 32'(sb_rd[lane] + 1), 32'(sb_wr[lane]));
    end
  endtask

  // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs.
  task automatic cycle();
    int         win;
    logic [3:0] exp_rdy;
    @(negedge clk);
    win = -1;
    if (rst_n && (!m_ov || out_ready))
      for (int k = 0; k < 4; k++)
        if (win < 0 && in_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    hs = in_valid & in_ready;
    if (rst_n && out_valid && out_ready) sb_pop(int'(out_sel), out_data);
    @(posedge clk);
    if (!rst_n) begin
      if (m_ov) sb_wr[m_os]--;
      m_ov  = 1'b0;
      m_od  = 8'h00;
      m_os  = 0;
      m_ptr = 0;
    end else if (win >= 0) begin
      m_ov  = 1'b1;
      m_od  = ch_data[win];
      m_os  = win;
      m_ptr = (win + 1) % 4;
      sb_mem[win][sb_wr[win]] = ch_data[win];
      sb_wr[win]++;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_sel",   32'(out_sel),   32'(m_os));
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (in_valid != 4'b0000 && n < max_cycles) begin
      cycle();
      in_valid = in_valid & ~hs;
      n++;
    end
    check("drain_timeout", 32'(in_valid), 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    m_ov      = 1'b0;
    m_od      = 8'h00;
    m_os      = 0;
    hs        = 4'b0000;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ch_data[c] = 8'h10 + 8'(c);
      sb_wr[c]   = 0;
      sb_rd[c]   = 0;
    end

    // Reset with every channel requesting
    in_valid = 4'b1111;
    cycle();
    cycle();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_sel",   32'(out_sel),   32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(in_ready), 32'h1);
    drain(8);

    // Single channel
    ch_data[2] = 8'hA5;
    in_valid   = 4'b0100;
    #1;
    check("single_ready", 32'(in_ready), 32'h4);
    cycle();
    in_valid = 4'b0000;
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_sel",   32'(out_sel),   32'h2);
    cycle();

    // Fresh pointer, then full round-robin
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) ch_data[c] = 8'h10 + 8'(c);
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_sel",   32'(out_sel),   32'(k % 4));
      check("rr_data",  32'(out_data),  32'(8'h10 + 8'(k % 4)));
    end
    in_valid = in_valid & ~hs;
    drain(8);

    // Backpressure while channels 0 and 3 wait
    in_valid = 4'b0010;
    cycle();
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_in_ready", 32'(in_ready),  32'h0);
      check("bp_valid",    32'(out_valid), 32'h1);
      check("bp_sel",      32'(out_sel),   32'h1);
      check("bp_data",     32'(out_data),  32'h11);
    end
    out_ready = 1'b1;
    cycle();
    in_valid = in_valid & ~hs;
    check("bp_next_sel",  32'(out_sel),  32'h3);
    check("bp_next_data", 32'(out_data), 32'h13);
    cycle();
    in_valid = in_valid & ~hs;
    check("bp_last_sel",  32'(out_sel),  32'h0);
    check("bp_last_data", 32'(out_data), 32'h10);

    // Wrap and skip from ptr = 3
    in_valid = 4'b0100;
    cycle();
    in_valid = 4'b1010;
    cycle();
    in_valid = in_valid & ~hs;
    check("wrap_first", 32'(out_sel), 32'h3);
    cycle();
    in_valid = in_valid & ~hs;
    check("wrap_second", 32'(out_sel), 32'h1);

    // Reset while a beat is stalled
    in_valid = 4'b0001;
    cycle();
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    cycle();
    check("mid_held", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0101;
    #1;
    check("mid_rst_ptr", 32'(in_ready), 32'h1);
    drain(8);

    // Random loopback traffic
    for (int n = 0; n < 1000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!in_valid[c] && ($urandom % 2 == 0)) begin
          in_valid[c] = 1'b1;
          ch_data[c]  = 8'($urandom);
        end
      end
      out_ready = ($urandom % 4) != 0;
      cycle();
      in_valid = in_valid & ~hs;
    end
    out_ready = 1'b1;
    drain(16);
    cycle();
    cycle();
    for (int c = 0; c < 4; c++) check("loopback_lost", 32'(sb_rd[c]), 32'(sb_wr[c]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
